// File: rtl/clock_mode_ctrl.sv
// Button-driven sequencer for the multi-mode clock: cycles modes, holds timer/alarm presets
// and runs an hh/mm/ss field editor with idle timeout.
module clock_mode_ctrl #(
   parameter int unsigned NUM_MODES    = 6,
   parameter int unsigned EDIT_TIMEOUT = 10,
   parameter int unsigned HH_MAX       = 23,
   parameter int unsigned MS_MAX       = 59
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        mode_btn,
   input  logic        set_btn,
   input  logic        inc_btn,
   input  logic        dec_btn,
   output logic [2:0]  current_mode,
   output logic        mode_rst,
   output logic [16:0] in,
   output logic        editing,
   output logic [1:0]  edit_field,
   output logic [16:0] edit_value
);

   localparam int unsigned IdleW = $clog2(EDIT_TIMEOUT + 1);

   localparam logic [2:0]       ModeTimer = 3'd3;
   localparam logic [2:0]       ModeAlarm = 3'd5;
   localparam logic [2:0]       LastMode  = 3'(NUM_MODES - 1);
   localparam logic [4:0]       HhMax     = 5'(HH_MAX);
   localparam logic [5:0]       MsMax     = 6'(MS_MAX);
   localparam logic [IdleW-1:0] IdleLast  = IdleW'(EDIT_TIMEOUT - 1);

   typedef enum logic [2:0] {StRun, StEditHh, StEditMm, StEditSs, StCommit} state_e;

   state_e           state_q, state_d;
   logic [2:0]       mode_q, mode_d;
   logic             mode_rst_q, mode_rst_d;
   logic [16:0]      in_q, in_d;
   logic             editing_q, editing_d;
   logic [1:0]       field_q, field_d;
   logic [16:0]      ev_q, ev_d;
   logic [16:0]      timer_q, timer_d;
   logic [16:0]      alarm_q, alarm_d;
   logic [IdleW-1:0] idle_q, idle_d;

   logic       mode_p, set_p, inc_p, dec_p;
   logic [2:0] mode_nxt;
   logic [4:0] hh;
   logic [5:0] mm, ss;

   function automatic logic [16:0] preset_sel(input logic [2:0]  m,
                                              input logic [16:0] tmr,
                                              input logic [16:0] alm);
      if (m == ModeTimer) return tmr;
      if (m == ModeAlarm) return alm;
      return 17'd0;
   endfunction

   function automatic logic [5:0] ms_step(input logic [5:0] v, input logic up);
      if (up) return (v >= MsMax) ? 6'd0 : v + 6'd1;
      return (v == 6'd0 || v > MsMax) ? MsMax : v - 6'd1;
   endfunction

   // Strict priority: only the highest-priority pulse of a cycle is serviced.
   assign mode_p = mode_btn;
   assign set_p  = set_btn & ~mode_btn;
   assign inc_p  = inc_btn & ~mode_btn & ~set_btn;
   assign dec_p  = dec_btn & ~mode_btn & ~set_btn & ~inc_btn;

   assign hh       = ev_q[16:12];
   assign mm       = ev_q[11:6];
   assign ss       = ev_q[5:0];
   assign mode_nxt = (mode_q >= LastMode) ? 3'd0 : mode_q + 3'd1;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      mode_rst_d = 1'b0;
      in_d       = in_q;
      editing_d  = editing_q;
      field_d    = field_q;
      ev_d       = ev_q;
      timer_d    = timer_q;
      alarm_d    = alarm_q;
      idle_d     = idle_q;

      unique case (state_q)
         StRun: begin
            // Buttons are dropped in the strobe cycle so mode_rst can never stay high twice.
            if (!mode_rst_q) begin
               if (mode_p) begin
                  mode_d     = mode_nxt;
                  in_d       = preset_sel(mode_nxt, timer_q, alarm_q);
                  mode_rst_d = 1'b1;
               end else if (set_p && (mode_q == ModeTimer || mode_q == ModeAlarm)) begin
                  ev_d      = preset_sel(mode_q, timer_q, alarm_q);
                  state_d   = StEditHh;
                  editing_d = 1'b1;
                  field_d   = 2'd1;
                  idle_d    = '0;
               end
            end
         end

         StEditHh, StEditMm, StEditSs: begin
            if (mode_p) begin
               state_d   = StRun;
               editing_d = 1'b0;
               field_d   = 2'd0;
               idle_d    = '0;
            end else if (set_p) begin
               idle_d = '0;
               case (state_q)
                  StEditHh: begin
                     state_d = StEditMm;
                     field_d = 2'd2;
                  end
                  StEditMm: begin
                     state_d = StEditSs;
                     field_d = 2'd3;
                  end
                  default: begin
                     state_d    = StCommit;
                     editing_d  = 1'b0;
                     field_d    = 2'd0;
                     in_d       = ev_q;
                     mode_rst_d = 1'b1;
                     if (mode_q == ModeTimer) timer_d = ev_q;
                     else alarm_d = ev_q;
                  end
               endcase
            end else if (inc_p || dec_p) begin
               idle_d = '0;
               case (state_q)
                  StEditHh: begin
                     if (inc_p) ev_d[16:12] = (hh >= HhMax) ? 5'd0 : hh + 5'd1;
                     else ev_d[16:12] = (hh == 5'd0 || hh > HhMax) ? HhMax : hh - 5'd1;
                  end
                  StEditMm: ev_d[11:6] = ms_step(mm, inc_p);
                  default:  ev_d[5:0]  = ms_step(ss, inc_p);
               endcase
            end else if (tick) begin
               if (idle_q >= IdleLast) begin
                  state_d   = StRun;
                  editing_d = 1'b0;
                  field_d   = 2'd0;
                  idle_d    = '0;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
         end

         StCommit: state_d = StRun;

         default: begin
            state_d   = StRun;
            editing_d = 1'b0;
            field_d   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StRun;
         mode_q     <= 3'd0;
         mode_rst_q <= 1'b0;
         in_q       <= 17'd0;
         editing_q  <= 1'b0;
         field_q    <= 2'd0;
         ev_q       <= 17'd0;
         timer_q    <= 17'd0;
         alarm_q    <= 17'd0;
         idle_q     <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         mode_rst_q <= mode_rst_d;
         in_q       <= in_d;
         editing_q  <= editing_d;
         field_q    <= field_d;
         ev_q       <= ev_d;
         timer_q    <= timer_d;
         alarm_q    <= alarm_d;
         idle_q     <= idle_d;
      end
   end

   assign current_mode = mode_q;
   assign mode_rst     = mode_rst_q;
   assign in           = in_q;
   assign editing      = editing_q;
   assign edit_field   = field_q;
   assign edit_value   = ev_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: a behavioural model pushes expected outputs to a
// scoreboard queue as each cycle of stimulus is driven; results are popped after the edge.
module tb_clock_mode_ctrl;

   logic        clk = 1'b0;
   logic        rst, tick, mode_btn, set_btn, inc_btn, dec_btn;
   logic [2:0]  current_mode;
   logic        mode_rst;
   logic [16:0] in;
   logic        editing;
   logic [1:0]  edit_field;
   logic [16:0] edit_value;

   clock_mode_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .mode_btn     (mode_btn),
      .set_btn      (set_btn),
      .inc_btn      (inc_btn),
      .dec_btn      (dec_btn),
      .current_mode (current_mode),
      .mode_rst     (mode_rst),
      .in           (in),
      .editing      (editing),
      .edit_field   (edit_field),
      .edit_value   (edit_value)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  mode;
      logic        mrst;
      logic [16:0] pre;
      logic        ed;
      logic [1:0]  fld;
      logic [16:0] ev;
   } exp_t;

   exp_t sb_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   // Reference model (0=run, 1..3=hh/mm/ss, 4=commit)
   int          m_state, m_mode, m_idle;
   logic        m_mrst;
   logic [16:0] m_in, m_ev, m_timer, m_alarm;

   function automatic logic [16:0] pack(input int h, input int m, input int s);
      logic [4:0] h5 = 5'(h);
      logic [5:0] m6 = 6'(m);
      logic [5:0] s6 = 6'(s);
      return {h5, m6, s6};
   endfunction

   function automatic logic [16:0] m_preset(input int md);
      if (md == 3) return m_timer;
      if (md == 5) return m_alarm;
      return 17'd0;
   endfunction

   task automatic m_reset();
      m_state = 0; m_mode = 0; m_idle = 0; m_mrst = 1'b0;
      m_in = '0; m_ev = '0; m_timer = '0; m_alarm = '0;
   endtask

   task automatic m_step(input bit mb, input bit sb, input bit ib, input bit db, input bit tk);
      int h, mi, s, delta;
      m_mrst = 1'b0;
      h  = int'(m_ev[16:12]);
      mi = int'(m_ev[11:6]);
      s  = int'(m_ev[5:0]);
      if (m_state == 0) begin
         if (mb) begin
            m_mode = (m_mode + 1) % 6;
            m_in   = m_preset(m_mode);
            m_mrst = 1'b1;
         end else if (sb && (m_mode == 3 || m_mode == 5)) begin
            m_ev = m_preset(m_mode); m_state = 1; m_idle = 0;
         end
      end else if (m_state == 4) begin
         m_state = 0;
      end else begin
         if (mb) begin
            m_state = 0; m_idle = 0;
         end else if (sb) begin
            m_idle = 0;
            if (m_state == 3) begin
               if (m_mode == 3) m_timer = m_ev; else m_alarm = m_ev;
               m_in = m_ev; m_mrst = 1'b1; m_state = 4;
            end else m_state++;
         end else if (ib || db) begin
            m_idle = 0;
            delta  = ib ? 1 : -1;
            if (m_state == 1) h = (h + delta + 24) % 24;
            else if (m_state == 2) mi = (mi + delta + 60) % 60;
            else s = (s + delta + 60) % 60;
            m_ev = pack(h, mi, s);
         end else if (tk) begin
            m_idle++;
            if (m_idle == 10) begin
               m_state = 0; m_idle = 0;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input bit mb, input bit sb, input bit ib,
                       input bit db, input bit tk);
      exp_t e;
      mode_btn = mb; set_btn = sb; inc_btn = ib; dec_btn = db; tick = tk;
      m_step(mb, sb, ib, db, tk);
      e.mode = 3'(m_mode); e.mrst = m_mrst; e.pre = m_in;
      e.ed   = (m_state >= 1 && m_state <= 3);
      e.fld  = (m_state >= 1 && m_state <= 3) ? 2'(m_state) : 2'd0;
      e.ev   = m_ev;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      mode_btn = 0; set_btn = 0; inc_btn = 0; dec_btn = 0; tick = 0;
      e = sb_q.pop_front();
      chk({tag, ".mode"}, 17'(current_mode), 17'(e.mode));
      chk({tag, ".mode_rst"}, 17'(mode_rst), 17'(e.mrst));
      chk({tag, ".in"}, in, e.pre);
      chk({tag, ".editing"}, 17'(editing), 17'(e.ed));
      chk({tag, ".field"}, 17'(edit_field), 17'(e.fld));
      if (e.ed) chk({tag, ".edit_value"}, edit_value, e.ev);
   endtask

   // Pulse followed by one quiet cycle.
   task automatic press(input string tag, input bit mb, input bit sb, input bit ib, input bit db,
                        input bit tk);
      step(tag, mb, sb, ib, db, tk);
      step({tag, ".gap"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      m_reset();
      chk("rst.mode", 17'(current_mode), 17'd0);
      chk("rst.in", in, 17'd0);
      chk("rst.mode_rst", 17'(mode_rst), 17'd0);
      chk("rst.editing", 17'(editing), 17'd0);
      chk("rst.field", 17'(edit_field), 17'd0);
      chk("rst.edit_value", edit_value, 17'd0);
   endtask

   initial begin
      rst = 1'b1; tick = 0; mode_btn = 0; set_btn = 0; inc_btn = 0; dec_btn = 0;
      m_reset();
      @(posedge clk);
      #1;
      do_reset(2);

      // Full mode cycle
      for (int i = 0; i < 6; i++) begin
         press("cycle", 1, 0, 0, 0, 0);
      end
      chk("cycle.wrap", 17'(current_mode), 17'd0);

      // Timer edit: 2:59:10
      repeat (3) press("to_timer", 1, 0, 0, 0, 0);
      press("t.set_hh", 0, 1, 0, 0, 0);
      repeat (2) press("t.inc_hh", 0, 0, 1, 0, 0);
      press("t.set_mm", 0, 1, 0, 0, 0);
      press("t.dec_mm", 0, 0, 0, 1, 0);
      press("t.set_ss", 0, 1, 0, 0, 0);
      repeat (10) press("t.inc_ss", 0, 0, 1, 0, 0);
      chk("t.in_frozen", in, 17'd0);
      step("t.commit", 0, 1, 0, 0, 0);
      chk("t.commit_rst", 17'(mode_rst), 17'd1);
      step("t.after", 0, 0, 0, 0, 0);
      chk("t.in_final", in, {5'd2, 6'd59, 6'd10});
      chk("t.rst_once", 17'(mode_rst), 17'd0);

      // Preset separation
      repeat (2) press("to_alarm", 1, 0, 0, 0, 0);
      chk("sep.alarm_in", in, 17'd0);
      repeat (4) press("back_timer", 1, 0, 0, 0, 0);
      chk("sep.timer_in", in, {5'd2, 6'd59, 6'd10});

      // Alarm edit: hour wrap then idle timeout
      repeat (2) press("to_alarm2", 1, 0, 0, 0, 0);
      press("a.set_hh", 0, 1, 0, 0, 0);
      press("a.dec_hh", 0, 0, 0, 1, 0);
      chk("a.hh_wrap", 17'(edit_value[16:12]), 17'd23);
      for (int i = 0; i < 10; i++) press("a.tick", 0, 0, 0, 0, 1);
      chk("a.timeout", 17'(editing), 17'd0);
      chk("a.preset_kept", in, 17'd0);

      // Ignored set, then mode+inc priority in EDIT_MM
      press("to_m0", 1, 0, 0, 0, 0);
      press("m0.set", 0, 1, 0, 0, 0);
      repeat (3) press("to_timer3", 1, 0, 0, 0, 0);
      press("p.set_hh", 0, 1, 0, 0, 0);
      press("p.set_inc", 0, 1, 1, 0, 0);
      press("p.mode_inc", 1, 0, 1, 0, 0);
      chk("p.mm_kept", 17'(edit_value[11:6]), 17'd59);
      chk("p.in_kept", in, {5'd2, 6'd59, 6'd10});

      // Reset mid-edit clears both presets
      press("r.set_hh", 0, 1, 0, 0, 0);
      press("r.inc_hh", 0, 0, 1, 0, 0);
      do_reset(2);
      repeat (3) press("r.to_timer", 1, 0, 0, 0, 0);
      chk("r.timer_cleared", in, 17'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
